// File: rtl/unified_mem_arbiter_if.sv
// Memory-side bus of the unified memory arbiter.
// master: the arbiter. It drives the request, write enable, address and write data,
//         and receives read data plus a one-cycle completion strobe.
// slave : the memory model or memory controller.
interface unified_mem_arbiter_if #(
  parameter int WIDTH     = 32,
  parameter int ADDRWIDTH = 32
);
  logic                 mem_req_o;
  logic                 mem_we_o;
  logic [ADDRWIDTH-1:0] mem_addr_o;
  logic [WIDTH-1:0]     mem_wdata_o;
  logic [WIDTH-1:0]     mem_rdata_i;
  logic                 mem_ack_i;

  modport master (
    output mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o,
    input  mem_rdata_i, mem_ack_i
  );

  modport slave (
    input  mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o,
    output mem_rdata_i, mem_ack_i
  );
endinterface

// File: rtl/unified_mem_arbiter.sv
// Shares one single-port memory between the instruction fetch port and the
// MEM-stage data port. Each pipeline step runs at most one data access and then
// one instruction fetch. busy_o stalls the core for the whole sequence.
//
// state  | meaning
// IDLE   | latch the CPU request (pc, ctrl, data addr, store data)
// D_ACC  | data access at data_addr + DATA_BASE; skipped when ctrl == 0
// I_ACC  | instruction fetch at the latched pc
// DONE   | busy_o low for one cycle; the core advances on this edge
//
// Ports: clk_i / rst_n_i (asynchronous, active-low); pc_i / ins_o (fetch);
//        mem_ctrl_i, data_addr_i, data_wdata_i / data_rdata_o (data port);
//        busy_o (core stall); err_o (sticky timeout); mem_if (memory bus).
module unified_mem_arbiter #(
  parameter int                   WIDTH     = 32,
  parameter int                   ADDRWIDTH = 32,
  parameter logic [ADDRWIDTH-1:0] DATA_BASE = 32'h0000_4000,
  parameter int                   MAX_WAIT  = 15
) (
  input  logic                 clk_i,
  input  logic                 rst_n_i,
  input  logic [ADDRWIDTH-1:0] pc_i,
  output logic [WIDTH-1:0]     ins_o,
  input  logic [1:0]           mem_ctrl_i,
  input  logic [WIDTH-1:0]     data_addr_i,
  input  logic [WIDTH-1:0]     data_wdata_i,
  output logic [WIDTH-1:0]     data_rdata_o,
  output logic                 busy_o,
  output logic                 err_o,
  unified_mem_arbiter_if.master mem_if
);

  localparam int                WAIT_W    = $clog2(MAX_WAIT + 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MAX_WAIT - 1);

  typedef enum logic [1:0] {IDLE, D_ACC, I_ACC, DONE} state_t;

  state_t               state_q, state_d;
  logic [ADDRWIDTH-1:0] pc_q, pc_d, daddr_q, daddr_d;
  logic [1:0]           ctrl_q, ctrl_d;
  logic [WIDTH-1:0]     wdata_q, wdata_d;
  logic [WIDTH-1:0]     ins_q, ins_d, rdata_q, rdata_d;
  logic                 err_q, err_d;
  logic [WAIT_W-1:0]    wait_q, wait_d;
  logic                 timeout;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    daddr_d = daddr_q;
    ctrl_d  = ctrl_q;
    wdata_d = wdata_q;
    ins_d   = ins_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    wait_d  = wait_q;
    timeout = 1'b0;
    case (state_q)
      IDLE: begin
        pc_d    = pc_i;
        daddr_d = ADDRWIDTH'(data_addr_i);
        ctrl_d  = mem_ctrl_i;
        wdata_d = data_wdata_i;
        wait_d  = '0;
        state_d = (mem_ctrl_i != 2'b00) ? D_ACC : I_ACC;
      end
      D_ACC, I_ACC: begin
        // The final allowed wait cycle without an ack closes the access
        // as if the memory had returned zero.
        timeout = !mem_if.mem_ack_i && (wait_q == WAIT_LAST);
        if (mem_if.mem_ack_i || timeout) begin
          wait_d = '0;
          if (timeout) err_d = 1'b1;
          if (state_q == D_ACC) begin
            state_d = I_ACC;
            // ctrl 11 runs as a write and clears the load result.
            if (ctrl_q == 2'b11)      rdata_d = '0;
            else if (ctrl_q == 2'b01) rdata_d = timeout ? '0 : mem_if.mem_rdata_i;
          end else begin
            state_d = DONE;
            ins_d   = timeout ? '0 : mem_if.mem_rdata_i;
          end
        end else begin
          wait_d = wait_q + WAIT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= IDLE;
      pc_q    <= '0;
      daddr_q <= '0;
      ctrl_q  <= '0;
      wdata_q <= '0;
      ins_q   <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      daddr_q <= daddr_d;
      ctrl_q  <= ctrl_d;
      wdata_q <= wdata_d;
      ins_q   <= ins_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      wait_q  <= wait_d;
    end
  end

  // The bus is decoded only from the registered state and latched request.
  // It stays stable until ack and drops as soon as reset asserts.
  always_comb begin
    mem_if.mem_req_o   = 1'b0;
    mem_if.mem_we_o    = 1'b0;
    mem_if.mem_addr_o  = '0;
    mem_if.mem_wdata_o = '0;
    case (state_q)
      D_ACC: begin
        mem_if.mem_req_o   = 1'b1;
        mem_if.mem_we_o    = ctrl_q[1];
        mem_if.mem_addr_o  = daddr_q + DATA_BASE;
        mem_if.mem_wdata_o = wdata_q;
      end
      I_ACC: begin
        mem_if.mem_req_o  = 1'b1;
        mem_if.mem_addr_o = pc_q;
      end
      default: ;
    endcase
  end

  assign busy_o       = (state_q != DONE);
  assign ins_o        = ins_q;
  assign data_rdata_o = rdata_q;
  assign err_o        = err_q;

endmodule

// File: tb/tb_unified_mem_arbiter.sv
module tb_unified_mem_arbiter;
  localparam int          MAX_WAIT  = 15;
  localparam logic [31:0] DATA_BASE = 32'h0000_4000;

  logic        clk_i = 1'b0;
  logic        rst_n_i = 1'b0;
  logic [31:0] pc_i = '0, data_addr_i = '0, data_wdata_i = '0;
  logic [1:0]  mem_ctrl_i = '0;
  logic [31:0] ins_o, data_rdata_o;
  logic        busy_o, err_o;

  unified_mem_arbiter_if #(.WIDTH(32), .ADDRWIDTH(32)) mem_if ();

  unified_mem_arbiter #(
    .WIDTH(32), .ADDRWIDTH(32), .DATA_BASE(DATA_BASE), .MAX_WAIT(MAX_WAIT)
  ) dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i), .pc_i(pc_i), .ins_o(ins_o),
    .mem_ctrl_i(mem_ctrl_i), .data_addr_i(data_addr_i), .data_wdata_i(data_wdata_i),
    .data_rdata_o(data_rdata_o), .busy_o(busy_o), .err_o(err_o), .mem_if(mem_if)
  );

  always #5 clk_i = ~clk_i;

  int checks = 0;
  int errors = 0;

  // Model state: what the core-facing outputs must hold.
  logic [31:0] m_ins = '0, m_rdata = '0;
  logic        m_err = 1'b0;
  // Per-cycle expectations, frozen when each cycle starts.
  logic        exp_valid = 1'b0, exp_req, exp_we, exp_busy, exp_err;
  logic [31:0] exp_addr, exp_wdata, exp_ins, exp_rdata;
  bit          pending_release = 1'b0;

  // Observation log of the bus accesses, used by the hand-written checks.
  logic [31:0] acc_addr[$], acc_wdata[$];
  logic        acc_we[$];
  int          acc_cyc[$];
  int          busy_low_cnt = 0;
  logic        prev_req = 1'b0, prev_we = 1'b0;
  logic [31:0] prev_addr = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic set_exp(input logic req, input logic we, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic busy);
    exp_valid = 1'b1;
    exp_req   = req;
    exp_we    = we;
    exp_addr  = addr;
    exp_wdata = wdata;
    exp_busy  = busy;
    exp_ins   = m_ins;
    exp_rdata = m_rdata;
    exp_err   = m_err;
  endtask

  task automatic scramble();
    pc_i         = $urandom;
    mem_ctrl_i   = 2'($urandom_range(0, 3));
    data_addr_i  = $urandom;
    data_wdata_i = $urandom;
    mem_if.mem_rdata_i = $urandom;
  endtask

  // Runs one pipeline step. wd/wi are the wait cycles before ack for the data
  // access and the fetch; a value >= MAX_WAIT means the memory never answers.
  task automatic run_seq(input logic [31:0] pc, input logic [1:0] ctrl,
                         input logic [31:0] daddr, input logic [31:0] wdata,
                         input int wd, input int wi,
                         input logic [31:0] rd_d, input logic [31:0] rd_i,
                         input bit stray, input bit abort);
    bit to;
    int n;
    // IDLE
    @(posedge clk_i); #1;
    set_exp(1'b0, 1'b0, '0, '0, 1'b1);
    scramble();
    pc_i = pc; mem_ctrl_i = ctrl; data_addr_i = daddr; data_wdata_i = wdata;
    mem_if.mem_ack_i = stray;
    if (pending_release) begin
      rst_n_i = 1'b1;
      pending_release = 1'b0;
    end
    if (ctrl != 2'b00) begin
      to = (wd >= MAX_WAIT);
      n  = to ? MAX_WAIT : wd + 1;
      for (int c = 0; c < n; c++) begin
        @(posedge clk_i); #1;
        set_exp(1'b1, ctrl[1], daddr + DATA_BASE, wdata, 1'b1);
        scramble();
        mem_if.mem_ack_i = (c == wd);
        if (c == wd) mem_if.mem_rdata_i = rd_d;
      end
      if (to) m_err = 1'b1;
      if (ctrl == 2'b11)      m_rdata = '0;
      else if (ctrl == 2'b01) m_rdata = to ? 32'h0 : rd_d;
    end
    to = (wi >= MAX_WAIT);
    n  = to ? MAX_WAIT : wi + 1;
    for (int c = 0; c < n; c++) begin
      @(posedge clk_i); #1;
      set_exp(1'b1, 1'b0, pc, '0, 1'b1);
      scramble();
      mem_if.mem_ack_i = (c == wi);
      if (c == wi) mem_if.mem_rdata_i = rd_i;
      if (abort) begin
        #2;
        rst_n_i = 1'b0;
        m_ins = '0; m_rdata = '0; m_err = 1'b0;
        set_exp(1'b0, 1'b0, '0, '0, 1'b1);
        #1;
        check("rst_mid_req", 32'(mem_if.mem_req_o), 32'd0);
        check("rst_mid_busy", 32'(busy_o), 32'd1);
        check("rst_mid_ins", ins_o, 32'd0);
        mem_if.mem_ack_i = 1'b0;
        pending_release = 1'b1;
        return;
      end
    end
    if (to) m_err = 1'b1;
    m_ins = to ? 32'h0 : rd_i;
    // DONE
    @(posedge clk_i); #1;
    set_exp(1'b0, 1'b0, '0, '0, 1'b0);
    scramble();
    mem_if.mem_ack_i = stray;
  endtask

  task automatic clear_obs();
    acc_addr.delete(); acc_we.delete(); acc_wdata.delete(); acc_cyc.delete();
    busy_low_cnt = 0;
  endtask

  task automatic settle();
    @(negedge clk_i); #1;
  endtask

  // Compare process: DUT against the model on every cycle.
  initial forever begin
    @(negedge clk_i);
    if (exp_valid) begin
      check("req",   32'(mem_if.mem_req_o), 32'(exp_req));
      check("we",    32'(mem_if.mem_we_o),  32'(exp_we));
      check("addr",  mem_if.mem_addr_o,     exp_addr);
      check("wdata", mem_if.mem_wdata_o,    exp_wdata);
      check("busy",  32'(busy_o),           32'(exp_busy));
      check("ins",   ins_o,                 exp_ins);
      check("rdata", data_rdata_o,          exp_rdata);
      check("err",   32'(err_o),            32'(exp_err));
    end
  end

  // Bus observer.
  initial forever begin
    @(negedge clk_i);
    if (!busy_o) busy_low_cnt++;
    if (mem_if.mem_req_o) begin
      if (!prev_req || mem_if.mem_addr_o != prev_addr || mem_if.mem_we_o != prev_we) begin
        acc_addr.push_back(mem_if.mem_addr_o);
        acc_we.push_back(mem_if.mem_we_o);
        acc_wdata.push_back(mem_if.mem_wdata_o);
        acc_cyc.push_back(1);
      end else begin
        acc_cyc[acc_cyc.size()-1]++;
      end
    end
    prev_req  = mem_if.mem_req_o;
    prev_addr = mem_if.mem_addr_o;
    prev_we   = mem_if.mem_we_o;
  end

  initial begin
    logic [31:0] daddr;
    int          wd, wi;
    mem_if.mem_ack_i   = 1'b0;
    mem_if.mem_rdata_i = '0;
    #12;
    check("reset_busy", 32'(busy_o), 32'd1);
    check("reset_req", 32'(mem_if.mem_req_o), 32'd0);
    check("reset_addr", mem_if.mem_addr_o, 32'd0);
    check("reset_ins", ins_o, 32'd0);
    check("reset_rdata", data_rdata_o, 32'd0);
    check("reset_err", 32'(err_o), 32'd0);
    pending_release = 1'b1;

    // Plain fetch with zero-wait memory.
    clear_obs();
    run_seq(32'h10, 2'b00, 32'h0, 32'h0, 0, 0, 32'h0, 32'h2002_0005, 1'b0, 1'b0);
    settle();
    check("fetch_ins", ins_o, 32'h2002_0005);
    check("fetch_busy_low", busy_low_cnt, 1);
    check("fetch_n_acc", acc_addr.size(), 1);
    if (acc_addr.size() == 1) begin
      check("fetch_addr", acc_addr[0], 32'h10);
      check("fetch_cycles", acc_cyc[0], 1);
    end

    // Load with two wait cycles.
    clear_obs();
    run_seq(32'h11, 2'b01, 32'h8, 32'h0, 2, 0, 32'hDEAD_BEEF, 32'h0000_0111, 1'b0, 1'b0);
    settle();
    check("load_rdata", data_rdata_o, 32'hDEAD_BEEF);
    check("load_busy_low", busy_low_cnt, 1);
    check("load_n_acc", acc_addr.size(), 2);
    if (acc_addr.size() == 2) begin
      check("load_daddr", acc_addr[0], 32'h4008);
      check("load_dwe", 32'(acc_we[0]), 32'd0);
      check("load_dcycles", acc_cyc[0], 3);
      check("load_iaddr", acc_addr[1], 32'h11);
    end

    // Store whose address wraps past the top of the address space.
    clear_obs();
    run_seq(32'h12, 2'b10, 32'hFFFF_C001, 32'h1234, 0, 1, 32'h5A5A, 32'h0000_0222, 1'b0, 1'b0);
    settle();
    check("store_rdata_hold", data_rdata_o, 32'hDEAD_BEEF);
    check("store_n_acc", acc_addr.size(), 2);
    if (acc_addr.size() == 2) begin
      check("store_addr", acc_addr[0], 32'h0000_0001);
      check("store_we", 32'(acc_we[0]), 32'd1);
      check("store_wdata", acc_wdata[0], 32'h1234);
      check("store_iaddr", acc_addr[1], 32'h12);
    end

    // Data read never acked: timeout.
    clear_obs();
    run_seq(32'h20, 2'b01, 32'h30, 32'h0, MAX_WAIT, 0, 32'h0, 32'h0BAD_F00D, 1'b0, 1'b0);
    settle();
    check("to_err", 32'(err_o), 32'd1);
    check("to_rdata", data_rdata_o, 32'd0);
    check("to_ins", ins_o, 32'h0BAD_F00D);
    check("to_n_acc", acc_addr.size(), 2);
    if (acc_addr.size() == 2) check("to_dcycles", acc_cyc[0], 15);

    // A good load later on; err_o stays set.
    run_seq(32'h21, 2'b01, 32'h40, 32'h0, 0, 1, 32'h5555_AAAA, 32'h0000_0013, 1'b0, 1'b0);
    settle();
    check("sticky_err", 32'(err_o), 32'd1);
    check("good_rdata", data_rdata_o, 32'h5555_AAAA);

    // ctrl 11 with stray acks in IDLE and DONE.
    clear_obs();
    run_seq(32'h22, 2'b11, 32'h5, 32'hCAFE, 0, 0, 32'h77, 32'h99, 1'b1, 1'b0);
    settle();
    check("ill_rdata", data_rdata_o, 32'd0);
    check("ill_busy_low", busy_low_cnt, 1);
    check("ill_n_acc", acc_addr.size(), 2);
    if (acc_addr.size() == 2) begin
      check("ill_addr", acc_addr[0], 32'h4005);
      check("ill_we", 32'(acc_we[0]), 32'd1);
      check("ill_wdata", acc_wdata[0], 32'hCAFE);
    end

    // Reset in the middle of a fetch; the next step restarts from IDLE.
    run_seq(32'h30, 2'b00, 32'h0, 32'h0, 0, 3, 32'h0, 32'h1111, 1'b0, 1'b1);
    run_seq(32'h31, 2'b01, 32'h2, 32'h0, 1, 0, 32'h4444, 32'h3333, 1'b0, 1'b0);
    settle();
    check("post_rst_err", 32'(err_o), 32'd0);
    check("post_rst_ins", ins_o, 32'h3333);

    // Random traffic.
    for (int k = 0; k < 150; k++) begin
      daddr = ($urandom_range(0, 3) == 0) ? 32'hFFFF_C000 + $urandom_range(0, 32'h4000)
                                          : $urandom;
      case ($urandom_range(0, 9))
        6:       wd = MAX_WAIT - 1;
        7:       wd = MAX_WAIT;
        8:       wd = MAX_WAIT + 5;
        9:       wd = $urandom_range(0, MAX_WAIT + 1);
        default: wd = $urandom_range(0, 3);
      endcase
      wi = ($urandom_range(0, 7) == 0) ? $urandom_range(MAX_WAIT - 1, MAX_WAIT + 1)
                                       : $urandom_range(0, 3);
      run_seq($urandom, 2'($urandom_range(0, 3)), daddr, $urandom, wd, wi,
              $urandom, $urandom, 1'($urandom_range(0, 1)), 1'b0);
    end
    settle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
